// File: rtl/uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl
//   Receive-side sequencer for a UART. Qualifies the start bit at mid-bit,
//   samples each following bit one bit period later using an oversampling
//   baud tick, shifts data in LSB-first and checks the stop bit. Completed
//   bytes go to the consumer through a one-entry valid/ready buffer.
//
// Parameters
//   DATA_BITS    data bits per frame (5..9)
//   OVERSAMPLE   baud_tick_i pulses per bit period (even, >= 8)
//
// Ports
//   clk_i         system clock, rising edge
//   rst_i         asynchronous active-high reset
//   baud_tick_i   1-cycle pulse, OVERSAMPLE per bit period
//   rx_datain_i   serial line, idle high, asynchronous to clk_i
//   rx_data_o     received byte, stable while rx_valid_o = 1
//   rx_valid_o    byte available, held until accepted
//   rx_ready_i    consumer accepts when rx_valid_o & rx_ready_i
//   frame_err_o   1-cycle pulse: stop bit sampled low
//   overrun_o     1-cycle pulse: byte completed while buffer full, byte dropped
//   rx_busy_o     high whenever the sequencer is not idle
//
// Build option
//   UART_PARITY_EN  adds a parity bit after the data bits, input parity_odd_i
//                   (1 = odd, 0 = even) and output parity_err_o (1-cycle pulse
//                   alongside delivery of a byte whose parity mismatched).
// ---------------------------------------------------------------------------
module uart_rx_ctrl #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 baud_tick_i,
    input  logic                 rx_datain_i,
`ifdef UART_PARITY_EN
    input  logic                 parity_odd_i,
    output logic                 parity_err_o,
`endif
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic                 frame_err_o,
    output logic                 overrun_o,
    output logic                 rx_busy_o
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TICK_W-1:0] MID_TICK = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] END_TICK = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_BITS - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_START    = 3'd1;
    localparam logic [2:0] S_DATA     = 3'd2;
`ifdef UART_PARITY_EN
    localparam logic [2:0] S_PARITY   = 3'd3;
`endif
    localparam logic [2:0] S_STOP     = 3'd4;
    localparam logic [2:0] S_BRK_WAIT = 3'd5;

    // Line synchroniser; both flops reset to the idle (high) level.
    logic                 sync1_q, sync2_q;
    logic                 rx_s;

    logic [2:0]           state_q,     state_d;
    logic [TICK_W-1:0]    tick_cnt_q,  tick_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q,   bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q,     shreg_d;
    logic [DATA_BITS-1:0] rx_data_q,   rx_data_d;
    logic                 rx_valid_q,  rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q,   overrun_d;
    logic                 deliver;
`ifdef UART_PARITY_EN
    logic                 par_bad_q,   par_bad_d;
    logic                 par_err_q,   par_err_d;
`endif

    assign rx_s = sync2_q;

    // Sequencer: counters only move on baud_tick_i, so a missing tick
    // simply freezes the frame in place.
    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        frame_err_d = 1'b0;
        deliver     = 1'b0;
`ifdef UART_PARITY_EN
        par_bad_d   = par_bad_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    tick_cnt_d = '0;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (baud_tick_i) begin
                    if (tick_cnt_q == MID_TICK) begin
                        tick_cnt_d = '0;
                        if (!rx_s) begin
                            bit_cnt_d = '0;
                            state_d   = S_DATA;
                        end else begin
                            // Line went back high before mid-bit: a glitch.
                            state_d   = S_IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (baud_tick_i) begin
                    if (tick_cnt_q == END_TICK) begin
                        tick_cnt_d = '0;
                        // LSB arrives first, so new bits enter at the top and
                        // walk down to their final position.
                        shreg_d    = {rx_s, shreg_q[DATA_BITS-1:1]};
                        if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (baud_tick_i) begin
                    if (tick_cnt_q == END_TICK) begin
                        tick_cnt_d = '0;
                        // Total ones over data+parity must be odd when
                        // parity_odd_i=1 and even otherwise.
                        par_bad_d  = ((^shreg_q) ^ rx_s) != parity_odd_i;
                        state_d    = S_STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
`endif
            S_STOP: begin
                if (baud_tick_i) begin
                    if (tick_cnt_q == END_TICK) begin
                        tick_cnt_d = '0;
                        if (rx_s) begin
                            deliver = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = S_BRK_WAIT;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            S_BRK_WAIT: begin
                // A held-low line (break) must not be mistaken for a new start.
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // One-entry output buffer. A handshake in the same cycle as a delivery
    // frees the slot, so the new byte is taken without an overrun.
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = 1'b0;
`ifdef UART_PARITY_EN
        par_err_d  = 1'b0;
`endif
        if (rx_valid_q && rx_ready_i) begin
            rx_valid_d = 1'b0;
        end
        if (deliver) begin
            if (rx_valid_q && !rx_ready_i) begin
                overrun_d = 1'b1;
            end else begin
                rx_data_d  = shreg_q;
                rx_valid_d = 1'b1;
`ifdef UART_PARITY_EN
                par_err_d  = par_bad_q;
`endif
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            state_q     <= S_IDLE;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_PARITY_EN
            par_bad_q   <= 1'b0;
            par_err_q   <= 1'b0;
`endif
        end else begin
            sync1_q     <= rx_datain_i;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_PARITY_EN
            par_bad_q   <= par_bad_d;
            par_err_q   <= par_err_d;
`endif
        end
    end

    assign rx_data_o   = rx_data_q;
    assign rx_valid_o  = rx_valid_q;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
    assign rx_busy_o   = (state_q != S_IDLE);
`ifdef UART_PARITY_EN
    assign parity_err_o = par_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_ctrl
//   Directed frames are driven onto the serial line with bit timing derived
//   from the bench's own baud-tick divider. Expected bytes and expected pulse
//   events are queued as each frame is issued; a monitor on the falling edge
//   pops and compares them on every handshake or status pulse.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_ctrl;
    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;
    localparam int TDIV       = 4;                      // clocks per baud tick
    localparam int BITC       = OVERSAMPLE * TDIV;      // clocks per bit
    // Cycle within each bit where the receiver samples: 2 synchroniser
    // cycles + 1 IDLE->START cycle, then OVERSAMPLE/2 ticks to mid-bit.
    localparam int MID_OFF    = 3 + TDIV * (OVERSAMPLE / 2 - 1);
    localparam int EV_FERR    = 1;
    localparam int EV_OVR     = 2;
    localparam int EV_PAR     = 3;

    logic                 clk       = 1'b0;
    logic                 rst       = 1'b1;
    logic                 baud_tick = 1'b0;
    logic                 rx_line   = 1'b1;
    logic                 rx_ready  = 1'b0;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 overrun;
    logic                 rx_busy;
`ifdef UART_PARITY_EN
    logic                 parity_odd = 1'b0;
    logic                 par_bit    = 1'b0;
    logic                 parity_err;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc_n    = 0;
    logic [DATA_BITS-1:0] exp_q[$];
    int                   evt_q[$];

    uart_rx_ctrl #(
        .DATA_BITS (DATA_BITS),
        .OVERSAMPLE(OVERSAMPLE)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .baud_tick_i (baud_tick),
        .rx_datain_i (rx_line),
`ifdef UART_PARITY_EN
        .parity_odd_i(parity_odd),
        .parity_err_o(parity_err),
`endif
        .rx_data_o   (rx_data),
        .rx_valid_o  (rx_valid),
        .rx_ready_i  (rx_ready),
        .frame_err_o (frame_err),
        .overrun_o   (overrun),
        .rx_busy_o   (rx_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic take_event(input int got);
        if (evt_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event: actual=%0d required=none", got);
        end else begin
            check("event", 32'(got), 32'(evt_q.pop_front()));
        end
    endtask

    // Scoreboard monitor, sampling mid-cycle.
    always @(negedge clk) begin
        if (rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_byte: actual=%0h required=none", rx_data);
            end else begin
                check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
            end
        end
        if (frame_err) take_event(EV_FERR);
        if (overrun)   take_event(EV_OVR);
`ifdef UART_PARITY_EN
        if (parity_err) take_event(EV_PAR);
`endif
        if (frame_err && overrun) begin
            checks++;
            failures++;
            $display("FAIL ferr_and_ovr: actual=both required=at most one");
        end
    end

    // Advance one cycle; inputs change 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc_n++;
        baud_tick = (cyc_n % TDIV == 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Start frames in the cycle just after a tick so sample points are exact.
    task automatic align();
        do step(); while (cyc_n % TDIV != 1);
    endtask

    // mode 1: raise rx_ready in the stop-sample cycle (concurrent handoff).
    // mode 2: check delivery latency around the stop-sample cycle.
    task automatic drive_bit(input logic v, input int mode, input logic [DATA_BITS-1:0] d);
        for (int i = 0; i < BITC; i++) begin
            rx_line = v;
            if (mode == 1 && i == MID_OFF) rx_ready = 1'b1;
            if (mode == 2 && i == MID_OFF) check("valid_at_stop_sample", 32'(rx_valid), 32'd0);
            if (mode == 2 && i == MID_OFF + 1) begin
                check("valid_after_stop", 32'(rx_valid), 32'd1);
                check("data_after_stop", 32'(rx_data), 32'(d));
                rx_ready = 1'b1;
            end
            if (mode == 2 && i == MID_OFF + 2) begin
                check("valid_after_accept", 32'(rx_valid), 32'd0);
                rx_ready = 1'b0;
            end
            step();
        end
    endtask

    task automatic send_frame(input logic [DATA_BITS-1:0] d, input logic stopb, input int mode);
        align();
        drive_bit(1'b0, 0, d);
        for (int b = 0; b < DATA_BITS; b++) drive_bit(d[b], 0, d);
`ifdef UART_PARITY_EN
        drive_bit(par_bit, 0, d);
`endif
        drive_bit(stopb, mode, d);
        if (stopb) rx_line = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] abort_d;
        abort_d = 8'h5A;

        // Reset state
        idle(3);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_rx_busy", 32'(rx_busy), 32'd0);
        rst = 1'b0;
        idle(5);

        // 1: clean 0x55, latency and clear-on-accept
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, 2);
        idle(10);

        // 2: 5-tick low glitch
        align();
        for (int i = 0; i < 5 * TDIV; i++) begin
            rx_line = 1'b0;
            if (i == 10) check("glitch_busy", 32'(rx_busy), 32'd1);
            step();
        end
        rx_line = 1'b1;
        idle(20);
        check("glitch_idle", 32'(rx_busy), 32'd0);
        check("glitch_valid", 32'(rx_valid), 32'd0);
        check("glitch_ferr", 32'(frame_err), 32'd0);

        // 3: bad stop bit, line held low 3 bit times
        rx_ready = 1'b1;
        evt_q.push_back(EV_FERR);
        send_frame(8'hA3, 1'b0, 0);
        drive_bit(1'b0, 0, 8'h00);
        check("break_busy", 32'(rx_busy), 32'd1);
        drive_bit(1'b0, 0, 8'h00);
        check("break_busy_end", 32'(rx_busy), 32'd1);
        check("break_valid", 32'(rx_valid), 32'd0);
        rx_line = 1'b1;
        idle(8);
        check("break_released", 32'(rx_busy), 32'd0);
        rx_ready = 1'b0;

        // 4a: two frames, consumer stalled -> second dropped
        exp_q.push_back(8'h11);
        evt_q.push_back(EV_OVR);
        send_frame(8'h11, 1'b1, 0);
        idle(10);
        send_frame(8'h22, 1'b1, 0);
        idle(40);
        check("ovr_valid_kept", 32'(rx_valid), 32'd1);
        check("ovr_data_kept", 32'(rx_data), 32'h11);
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        idle(3);
        check("ovr_drained", 32'(rx_valid), 32'd0);

        // 4b: accept in the delivery cycle of the second frame
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        send_frame(8'h11, 1'b1, 0);
        idle(10);
        send_frame(8'h22, 1'b1, 1);
        idle(5);
        rx_ready = 1'b0;
        check("handoff_drained", 32'(rx_valid), 32'd0);

        // 5: buffered byte, then reset during bit 4 of the next frame
        send_frame(8'h99, 1'b1, 0);
        idle(5);
        check("pre_rst_valid", 32'(rx_valid), 32'd1);
        check("pre_rst_data", 32'(rx_data), 32'h99);
        align();
        drive_bit(1'b0, 0, abort_d);
        for (int b = 0; b < 4; b++) drive_bit(abort_d[b], 0, abort_d);
        for (int i = 0; i < BITC / 2; i++) begin
            rx_line = abort_d[4];
            step();
        end
        check("mid_frame_busy", 32'(rx_busy), 32'd1);
        rst = 1'b1;
        rx_line = 1'b1;
        step();
        check("midrst_data", 32'(rx_data), 32'd0);
        check("midrst_valid", 32'(rx_valid), 32'd0);
        check("midrst_busy", 32'(rx_busy), 32'd0);
        check("midrst_ferr", 32'(frame_err), 32'd0);
        check("midrst_ovr", 32'(overrun), 32'd0);
        idle(2);
        rst = 1'b0;
        idle(5);
        check("post_rst_busy", 32'(rx_busy), 32'd0);
        rx_ready = 1'b1;
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 0);

        // Data extremes
        exp_q.push_back(8'hFF);
        send_frame(8'hFF, 1'b1, 0);
        exp_q.push_back(8'h00);
        send_frame(8'h00, 1'b1, 0);

`ifdef UART_PARITY_EN
        // 6: even parity, 0x07 has three ones
        parity_odd = 1'b0;
        par_bit    = 1'b0;
        exp_q.push_back(8'h07);
        evt_q.push_back(EV_PAR);
        send_frame(8'h07, 1'b1, 0);
        par_bit = 1'b1;
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 0);
        parity_odd = 1'b1;
        par_bit    = 1'b0;
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 0);
        par_bit = 1'b0;
`endif

        idle(20);
        rx_ready = 1'b0;
        check("bytes_all_seen", 32'(exp_q.size()), 32'd0);
        check("events_all_seen", 32'(evt_q.size()), 32'd0);
        check("final_idle", 32'(rx_busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
